// File: rtl/skor_tablosu_pkg.sv
// Shared definitions for the score board: state encoding, player indices
// and the width of the per-round point value.
package skor_tablosu_pkg;

  localparam int PUAN_W = 5;

  typedef logic [1:0] durum_t;
  typedef logic [1:0] oyuncu_t;

  localparam logic [1:0] BOSTA = 2'd0;
  localparam logic [1:0] OYUN  = 2'd1;
  localparam logic [1:0] HESAP = 2'd2;
  localparam logic [1:0] BITTI = 2'd3;

  localparam oyuncu_t YOK = 2'd0;
  localparam oyuncu_t P1  = 2'd1;
  localparam oyuncu_t P2  = 2'd2;
  localparam oyuncu_t P3  = 2'd3;

endpackage

// File: rtl/skor_tablosu_if.sv
// Round-result handshake between the upstream match stage and the score board.
interface skor_tablosu_if;
  import skor_tablosu_pkg::*;

  logic              basla;
  logic              tur_gecerli;
  logic [1:0]        kazanan;
  logic [PUAN_W-1:0] toplam_puan;
  logic              hazir;

  modport master (
    output basla, tur_gecerli, kazanan, toplam_puan,
    input  hazir
  );

  modport slave (
    input  basla, tur_gecerli, kazanan, toplam_puan,
    output hazir
  );
endinterface

// File: rtl/skor_tablosu_doygun_topla.sv
// Per-player score register with a saturating add of the round's points.
module doygun_topla
  import skor_tablosu_pkg::*;
#(
  parameter int SKOR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              temizle,
  input  logic              ekle,
  input  logic [PUAN_W-1:0] puan,
  output logic [SKOR_W-1:0] skor
);

  // One extra bit keeps the carry so overflow can be detected.
  localparam int TOP_W = ((SKOR_W > PUAN_W) ? SKOR_W : PUAN_W) + 1;

  logic [SKOR_W-1:0] skor_q, skor_d;
  logic [SKOR_W-1:0] tavan;
  logic [TOP_W-1:0]  toplam;

  always_comb begin
    tavan  = '1;
    toplam = TOP_W'(skor_q) + TOP_W'(puan);
    skor_d = skor_q;
    if (temizle) begin
      skor_d = '0;
    end else if (ekle) begin
      skor_d = (toplam > TOP_W'(tavan)) ? tavan : toplam[SKOR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skor_q <= '0;
    end else begin
      skor_q <= skor_d;
    end
  end

  assign skor = skor_q;

endmodule

// File: rtl/skor_tablosu.sv
// Game score board: accumulates round winners' points for three players and
// names the champion once TUR_SAYISI rounds have been accepted.
module skor_tablosu
  import skor_tablosu_pkg::*;
#(
  parameter int TUR_SAYISI = 8,
  parameter int SKOR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  skor_tablosu_if.slave     bus,
  output logic [SKOR_W-1:0] skor1,
  output logic [SKOR_W-1:0] skor2,
  output logic [SKOR_W-1:0] skor3,
  output logic [3:0]        tur,
  output logic [1:0]        sampiyon,
  output logic              oyun_bitti
);

  durum_t     durum_q, durum_d;
  logic [3:0] tur_q, tur_d;
  oyuncu_t    sampiyon_q, sampiyon_d;
  logic       kabul;
  logic       son_tur;

  // A start request wins over a coincident round, which is dropped.
  assign kabul   = (durum_q == OYUN) && bus.tur_gecerli && !bus.basla;
  assign son_tur = (tur_q + 4'd1) == 4'(TUR_SAYISI);

  doygun_topla #(.SKOR_W(SKOR_W)) u_topla1 (
    .clk(clk), .rst(rst), .temizle(bus.basla),
    .ekle(kabul && (bus.kazanan == P1)),
    .puan(bus.toplam_puan), .skor(skor1)
  );

  doygun_topla #(.SKOR_W(SKOR_W)) u_topla2 (
    .clk(clk), .rst(rst), .temizle(bus.basla),
    .ekle(kabul && (bus.kazanan == P2)),
    .puan(bus.toplam_puan), .skor(skor2)
  );

  doygun_topla #(.SKOR_W(SKOR_W)) u_topla3 (
    .clk(clk), .rst(rst), .temizle(bus.basla),
    .ekle(kabul && (bus.kazanan == P3)),
    .puan(bus.toplam_puan), .skor(skor3)
  );

  always_comb begin
    durum_d    = durum_q;
    tur_d      = tur_q;
    sampiyon_d = sampiyon_q;
    if (bus.basla) begin
      durum_d    = OYUN;
      tur_d      = 4'd0;
      sampiyon_d = YOK;
    end else begin
      case (durum_q)
        OYUN: begin
          if (kabul) begin
            tur_d = tur_q + 4'd1;
            if (son_tur) durum_d = HESAP;
          end
        end
        HESAP: begin
          // Only a strictly highest score names a champion; any tie gives YOK.
          if ((skor1 > skor2) && (skor1 > skor3)) sampiyon_d = P1;
          else if ((skor2 > skor1) && (skor2 > skor3)) sampiyon_d = P2;
          else if ((skor3 > skor1) && (skor3 > skor2)) sampiyon_d = P3;
          else sampiyon_d = YOK;
          durum_d = BITTI;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      durum_q    <= BOSTA;
      tur_q      <= 4'd0;
      sampiyon_q <= YOK;
    end else begin
      durum_q    <= durum_d;
      tur_q      <= tur_d;
      sampiyon_q <= sampiyon_d;
    end
  end

  assign bus.hazir  = (durum_q == OYUN);
  assign oyun_bitti = (durum_q == BITTI);
  assign tur        = tur_q;
  assign sampiyon   = sampiyon_q;

endmodule

// File: tb/tb_skor_tablosu.sv
// Self-checking bench: two score boards (8-bit and 5-bit scores) driven with
// identical rounds and checked every cycle against a rule-level model.
module tb_skor_tablosu;
  import skor_tablosu_pkg::*;

  localparam int TS = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       basla;
  logic       tur_gecerli;
  logic [1:0] kazanan;
  logic [4:0] puan;

  always #5 clk = ~clk;

  skor_tablosu_if if8 ();
  skor_tablosu_if if5 ();

  assign if8.basla = basla;
  assign if8.tur_gecerli = tur_gecerli;
  assign if8.kazanan = kazanan;
  assign if8.toplam_puan = puan;
  assign if5.basla = basla;
  assign if5.tur_gecerli = tur_gecerli;
  assign if5.kazanan = kazanan;
  assign if5.toplam_puan = puan;

  logic [7:0] a_s1, a_s2, a_s3;
  logic [4:0] b_s1, b_s2, b_s3;
  logic [3:0] a_tur, b_tur;
  logic [1:0] a_sam, b_sam;
  logic       a_bit, b_bit;

  skor_tablosu #(.TUR_SAYISI(TS), .SKOR_W(8)) dut8 (
    .clk(clk), .rst(rst), .bus(if8.slave),
    .skor1(a_s1), .skor2(a_s2), .skor3(a_s3),
    .tur(a_tur), .sampiyon(a_sam), .oyun_bitti(a_bit)
  );

  skor_tablosu #(.TUR_SAYISI(TS), .SKOR_W(5)) dut5 (
    .clk(clk), .rst(rst), .bus(if5.slave),
    .skor1(b_s1), .skor2(b_s2), .skor3(b_s3),
    .tur(b_tur), .sampiyon(b_sam), .oyun_bitti(b_bit)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 playing, 2 evaluating, 3 finished
  int m_phase, m_rounds;
  int m8[1:3];
  int m5[1:3];
  int m_champ8, m_champ5;

  function automatic int champion(input int a, input int b, input int c);
    int best, n, who;
    best = a;
    if (b > best) best = b;
    if (c > best) best = c;
    n = 0; who = 0;
    if (a == best) begin n++; who = 1; end
    if (b == best) begin n++; who = 2; end
    if (c == best) begin n++; who = 3; end
    return (n == 1) ? who : 0;
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_rounds = 0; m_champ8 = 0; m_champ5 = 0;
      for (int i = 1; i <= 3; i++) begin m8[i] = 0; m5[i] = 0; end
    end else if (basla) begin
      m_phase = 1; m_rounds = 0; m_champ8 = 0; m_champ5 = 0;
      for (int i = 1; i <= 3; i++) begin m8[i] = 0; m5[i] = 0; end
    end else if (m_phase == 1) begin
      if (tur_gecerli) begin
        if (kazanan != 0) begin
          m8[kazanan] = sat(m8[kazanan] + int'(puan), 8);
          m5[kazanan] = sat(m5[kazanan] + int'(puan), 5);
        end
        m_rounds++;
        if (m_rounds == TS) m_phase = 2;
      end
    end else if (m_phase == 2) begin
      m_champ8 = champion(m8[1], m8[2], m8[3]);
      m_champ5 = champion(m5[1], m5[2], m5[3]);
      m_phase  = 3;
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("hazir8", int'(if8.hazir), int'(m_phase == 1));
      chk("hazir5", int'(if5.hazir), int'(m_phase == 1));
      chk("bitti8", int'(a_bit), int'(m_phase == 3));
      chk("bitti5", int'(b_bit), int'(m_phase == 3));
      chk("tur8", int'(a_tur), m_rounds);
      chk("tur5", int'(b_tur), m_rounds);
      chk("skor1_8", int'(a_s1), m8[1]);
      chk("skor2_8", int'(a_s2), m8[2]);
      chk("skor3_8", int'(a_s3), m8[3]);
      chk("skor1_5", int'(b_s1), m5[1]);
      chk("skor2_5", int'(b_s2), m5[2]);
      chk("skor3_5", int'(b_s3), m5[3]);
      chk("sampiyon8", int'(a_sam), m_champ8);
      chk("sampiyon5", int'(b_sam), m_champ5);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(); @(negedge clk); endtask

  task automatic round(input int k, input int p);
    tur_gecerli = 1'b1; kazanan = 2'(k); puan = 5'(p);
    tick();
    tur_gecerli = 1'b0; kazanan = 2'd0; puan = 5'd0;
    $display("round kazanan=%0d puan=%0d -> tur=%0d s1=%0d s2=%0d s3=%0d",
             k, p, a_tur, a_s1, a_s2, a_s3);
  endtask

  task automatic start();
    basla = 1'b1;
    tick();
    basla = 1'b0;
  endtask

  initial begin
    rst = 1'b1; basla = 1'b0; tur_gecerli = 1'b0; kazanan = 2'd0; puan = 5'd0;
    tick(); tick();
    rst = 1'b0;
    cmp_en = 1'b1;
    tick();
    chk("reset_hazir", int'(if8.hazir), 0);
    chk("reset_tur", int'(a_tur), 0);

    start();
    chk("start_hazir", int'(if8.hazir), 1);
    chk("start_bitti", int'(a_bit), 0);

    round(1, 10); round(3, 5); round(1, 7); round(0, 9);
    chk("g1_t1_bitti", int'(a_bit), 0);
    chk("g1_t1_tur", int'(a_tur), 4);
    chk("g1_t1_hazir", int'(if8.hazir), 0);
    tick();
    chk("g1_bitti", int'(a_bit), 1);
    chk("g1_sampiyon", int'(a_sam), 1);
    chk("g1_skor1", int'(a_s1), 17);
    chk("g1_skor3", int'(a_s3), 5);

    // rounds offered while finished are ignored
    tur_gecerli = 1'b1; kazanan = 2'd2; puan = 5'd9;
    tick(); tick(); tick();
    tur_gecerli = 1'b0; kazanan = 2'd0; puan = 5'd0;
    chk("bitti_hold_skor2", int'(a_s2), 0);
    chk("bitti_hold_tur", int'(a_tur), 4);

    start();
    round(2, 8); round(3, 8); round(0, 4); round(0, 4);
    tick();
    chk("g2_bitti", int'(a_bit), 1);
    chk("g2_tie", int'(a_sam), 0);

    start();
    round(2, 20); round(2, 20); round(0, 0); round(0, 0);
    chk("sat_skor2_w5", int'(b_s2), 31);
    chk("sat_skor2_w8", int'(a_s2), 40);
    tick();
    chk("sat_sampiyon", int'(b_sam), 2);

    // restart with a coincident round: the round is dropped
    start();
    basla = 1'b1; tur_gecerli = 1'b1; kazanan = 2'd1; puan = 5'd5;
    tick();
    basla = 1'b0; tur_gecerli = 1'b0; kazanan = 2'd0; puan = 5'd0;
    chk("coinc_skor1", int'(a_s1), 0);
    chk("coinc_tur", int'(a_tur), 0);
    chk("coinc_hazir", int'(if8.hazir), 1);

    // reset mid-game, then rounds ignored until basla
    round(1, 3); round(2, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_skor1", int'(a_s1), 0);
    chk("rst_tur", int'(a_tur), 0);
    chk("rst_hazir", int'(if8.hazir), 0);
    round(1, 5);
    chk("idle_ignore_skor1", int'(a_s1), 0);
    chk("idle_ignore_tur", int'(a_tur), 0);

    // reset after a finished game drops the champion
    start();
    round(3, 6); round(0, 1); round(0, 1); round(0, 1);
    tick();
    chk("g4_sampiyon", int'(a_sam), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_bitti_sampiyon", int'(a_sam), 0);
    chk("rst_bitti_flag", int'(a_bit), 0);
    tick();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/skor_tablosu.md
SKOR_TABLOSU -- requirements
Module: skor_tablosu

Interface
REQ-001 Parameter TUR_SAYISI, default 8, rounds per game (legal range 1..15).
REQ-002 Parameter SKOR_W, default 8, width of each per-player score accumulator.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 basla  input  1  start/restart request for a game.
REQ-006 tur_gecerli  input  1  round result valid from the upstream kapisma stage.
REQ-007 kazanan  input  2  round winner: 0 = none, 1..3 = player index.
REQ-008 toplam_puan  input  5  points awarded this round (0..31).
REQ-009 hazir  output  1  block accepts a round this cycle.
REQ-010 skor1, skor2, skor3  output  SKOR_W each  accumulated per-player scores.
REQ-011 tur  output  4  number of rounds accepted in the current game.
REQ-012 sampiyon  output  2  game champion: 0 = none/tie, 1..3 = player.
REQ-013 oyun_bitti  output  1  game complete; sampiyon valid.

Function
REQ-014 The FSM SHALL have four states: BOSTA (idle), OYUN (playing), HESAP (evaluate), BITTI (done).
REQ-015 BOSTA: hazir=0; basla=1 -> clear scores, tur and sampiyon; next state OYUN.
REQ-016 OYUN: hazir=1; a round is accepted when tur_gecerli=1 and hazir=1.
REQ-017 On accept, if kazanan is nonzero, that player's score SHALL become score+toplam_puan, saturating at 2^SKOR_W-1, visible the next cycle.
REQ-018 On accept with kazanan=0, no score changes, but the round counts.
REQ-019 Every accept increments tur by 1, visible the next cycle.
REQ-020 The accept that makes tur equal TUR_SAYISI moves the FSM to HESAP; hazir=0 in HESAP.
REQ-021 HESAP, one cycle: sampiyon registers the index of the strictly highest score; if the highest score is shared by two or more players (including all-zero), sampiyon=0; next state BITTI.
REQ-022 BITTI: oyun_bitti=1, hazir=0; scores, tur and sampiyon hold.
REQ-023 Latency: final accept at cycle t -> HESAP at t+1 -> oyun_bitti=1 with valid sampiyon at t+2.
REQ-024 basla=1 in OYUN, HESAP or BITTI SHALL clear scores, tur, sampiyon and oyun_bitti and enter OYUN next cycle.
REQ-025 When basla=1, a coincident round is discarded.
REQ-026 tur_gecerli outside OYUN SHALL be ignored, with no state or score change.
REQ-027 oyun_bitti is 0 in every state except BITTI.
REQ-028 All outputs SHALL be registered or decoded directly from the state register; there is no combinational path from inputs to outputs.

Reset
REQ-029 rst=1 SHALL force state BOSTA, skor1..3=0, tur=0, sampiyon=0, oyun_bitti=0, hazir=0 on the next edge.
REQ-030 rst SHALL take priority over basla and tur_gecerli, including mid-game.
REQ-031 Reset in HESAP or BITTI SHALL abandon the result, with no champion reported.

Structure
REQ-032 A shared package SHALL hold the state encoding (BOSTA/OYUN/HESAP/BITTI), the player-index constants (YOK=0, P1..P3) and the toplam_puan width (5).
REQ-033 One sub-module, doygun_topla (saturating adder, SKOR_W-bit accumulator plus 5-bit addend), SHALL be instantiated three times, once per player.
REQ-034 Champion comparison stays inline in skor_tablosu.

Verification (TUR_SAYISI=4)
REQ-035 Reset, then basla -> OYUN next cycle, hazir=1, all scores 0, tur=0, oyun_bitti=0.
REQ-036 Rounds (1,10),(3,5),(1,7),(0,9) -> skor1=17, skor2=0, skor3=5, tur=4; two cycles after the last accept, oyun_bitti=1 and sampiyon=1.
REQ-037 Rounds (2,8),(3,8),(0,4),(0,4) -> tie at 8, so sampiyon=0 with oyun_bitti=1.
REQ-038 Saturation: SKOR_W=5, rounds (2,20),(2,20) -> skor2=31, not 8.
REQ-039 Boundaries: tur_gecerli held high in BITTI -> no change; basla coincident with a round in OYUN -> round discarded, scores 0, tur=0.
REQ-040 rst asserted after 2 accepted rounds -> all outputs 0, state BOSTA; a following tur_gecerli is ignored until basla.
